// File: rtl/glorb_fetch.sv
// glorbcore fetch stage: owns the pc, keeps at most one imem read in flight and
// holds one fetched {instruction, pc} for execute; redirects squash wrong-path data.
module glorb_fetch #(
  parameter int              IW       = 8,
  parameter int              IMW      = 4,
  parameter logic [IMW-1:0]  RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic           imem_req_valid,
  input  logic           imem_req_ready,
  output logic [IMW-1:0] imem_req_addr,
  input  logic           imem_rsp_valid,
  input  logic [IW-1:0]  imem_rsp_data,
  output logic           ex_valid,
  input  logic           ex_ready,
  output logic [IW-1:0]  ex_instruction,
  output logic [IMW-1:0] ex_pc,
  input  logic           redirect_valid,
  input  logic [IMW-1:0] redirect_pc,
  output logic [1:0]     dbg_state_o
);

  // Handshakes: a request transfers on a rising edge with imem_req_valid and
  // imem_req_ready both high; the ex buffer transfers on an edge with ex_valid
  // and ex_ready high (ex_ready is ignored while redirect_valid is high), and
  // ex_instruction/ex_pc hold steady while ex_valid is high and not consumed.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IMW-1:0] fetch_pc_q, fetch_pc_d;
  logic [IMW-1:0] pend_pc_q, pend_pc_d;
  logic           drop_q, drop_d;
  logic           ex_valid_q, ex_valid_d;
  logic [IW-1:0]  ex_instr_q, ex_instr_d;
  logic [IMW-1:0] ex_pc_q, ex_pc_d;
  logic           req_valid;
  logic           req_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= '0;
      drop_q     <= 1'b0;
      ex_valid_q <= 1'b0;
      ex_instr_q <= '0;
      ex_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      drop_q     <= drop_d;
      ex_valid_q <= ex_valid_d;
      ex_instr_q <= ex_instr_d;
      ex_pc_q    <= ex_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    drop_d     = drop_q;
    ex_valid_d = ex_valid_q;
    ex_instr_d = ex_instr_q;
    ex_pc_d    = ex_pc_q;

    // Issuing only when the buffer is free (or draining) means a response can
    // never land on an unconsumed instruction.
    req_valid = (state_q == S_REQ) && !redirect_valid && (!ex_valid_q || ex_ready);
    req_fire  = req_valid && imem_req_ready;

    if (ex_valid_q && ex_ready) begin
      ex_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (req_fire) begin
          pend_pc_d  = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + IMW'(1);
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_d = S_REQ;
          drop_d  = 1'b0;
          if (!drop_q && !redirect_valid) begin
            ex_valid_d = 1'b1;
            ex_instr_d = imem_rsp_data;
            ex_pc_d    = pend_pc_q;
          end
        end else if (redirect_valid) begin
          // The in-flight read is now wrong-path; swallow it when it returns.
          drop_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      ex_valid_d = 1'b0;
    end
  end

  assign imem_req_valid = req_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign ex_valid       = ex_valid_q;
  assign ex_instruction = ex_instr_q;
  assign ex_pc          = ex_pc_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_glorb_fetch.sv
// Bench for glorb_fetch: directed scenarios with literal expectations plus a
// randomized run checked every cycle against an architectural program-order model.
module tb_glorb_fetch;
  localparam int IW  = 8;
  localparam int IMW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic           imem_req_valid, imem_req_ready;
  logic [IMW-1:0] imem_req_addr;
  logic           imem_rsp_valid;
  logic [IW-1:0]  imem_rsp_data;
  logic           ex_valid, ex_ready;
  logic [IW-1:0]  ex_instruction;
  logic [IMW-1:0] ex_pc;
  logic           redirect_valid;
  logic [IMW-1:0] redirect_pc;
  logic [1:0]     dbg_state;

  glorb_fetch #(.IW(IW), .IMW(IMW), .RESET_PC(4'd0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_instruction(ex_instruction), .ex_pc(ex_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dbg_state_o(dbg_state)
  );

  // Second instance for the pc wrap scenario (RESET_PC = 14).
  logic           w_rst_n, w_req_valid, w_rsp_valid, w_ex_valid;
  logic [IMW-1:0] w_req_addr, w_ex_pc;
  logic [IW-1:0]  w_rsp_data, w_ex_instr;
  logic [1:0]     w_dbg;

  glorb_fetch #(.IW(IW), .IMW(IMW), .RESET_PC(4'd14)) dut_w (
    .clk(clk), .rst_n(w_rst_n),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
    .imem_req_addr(w_req_addr), .imem_rsp_valid(w_rsp_valid),
    .imem_rsp_data(w_rsp_data), .ex_valid(w_ex_valid), .ex_ready(1'b1),
    .ex_instruction(w_ex_instr), .ex_pc(w_ex_pc),
    .redirect_valid(1'b0), .redirect_pc(4'd0),
    .dbg_state_o(w_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_total = 0;
  logic [IMW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  logic [IW-1:0]  mem [16];
  logic [IMW-1:0] del_pc_q[$];
  logic [IW-1:0]  del_instr_q[$];
  int             del_cyc_q[$];
  int             cyc_l = 0;

  // Architectural model: delivered instructions follow program order from
  // RESET_PC, restarting at redirect_pc after each redirect; fetch addresses
  // follow the same rule one request at a time.
  logic [IMW-1:0] exp_pc, exp_fetch, hold_pc;
  logic [IW-1:0]  hold_instr;
  logic           prev_hold, prev_redirect;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc        = 4'd0;
      exp_fetch     = 4'd0;
      prev_hold     = 1'b0;
      prev_redirect = 1'b0;
    end else begin
      if (redirect_valid) chk("req_in_redirect", imem_req_valid, 0);
      if (imem_req_valid) chk("req_gate", !ex_valid || ex_ready, 1);
      if (prev_redirect) chk("ex_valid_after_redirect", ex_valid, 0);
      if (prev_hold) begin
        chk("hold_valid", ex_valid, 1);
        chk("hold_pc", ex_pc, hold_pc);
        chk("hold_instr", ex_instruction, hold_instr);
      end
      if (ex_valid) begin
        chk("ex_pc", ex_pc, exp_pc);
        chk("ex_instr", ex_instruction, mem[ex_pc]);
      end
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, exp_fetch);
        exp_fetch = exp_fetch + 4'd1;
      end
      if (redirect_valid) begin
        exp_pc    = redirect_pc;
        exp_fetch = redirect_pc;
      end else if (ex_valid && ex_ready) begin
        del_pc_q.push_back(ex_pc);
        del_instr_q.push_back(ex_instruction);
        del_cyc_q.push_back(cyc_l);
        exp_pc = exp_pc + 4'd1;
      end
      prev_redirect = redirect_valid;
      prev_hold     = ex_valid && !ex_ready && !redirect_valid;
      hold_pc       = ex_pc;
      hold_instr    = ex_instruction;
    end
  end

  // ---------------- driver tasks ----------------
  logic           out_busy = 1'b0;
  logic [IMW-1:0] out_addr = '0;
  int             out_due = 0;
  int             acc_cnt = 0;
  int             lat_min = 1, lat_max = 1;

  // Entered at posedge+1 with this cycle's inputs set; returns at next posedge+1.
  task automatic cycle_step();
    imem_rsp_valid = out_busy && (cyc_l == out_due);
    imem_rsp_data  = imem_rsp_valid ? mem[out_addr] : IW'($urandom);
    @(negedge clk);
    if (imem_rsp_valid) out_busy = 1'b0;
    if (imem_req_valid && imem_req_ready) begin
      chk("single_outstanding", out_busy, 0);
      out_busy = 1'b1;
      out_addr = imem_req_addr;
      out_due  = cyc_l + $urandom_range(lat_max, lat_min);
      acc_cnt++;
    end
    @(posedge clk);
    #1;
    cyc_l++;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    out_busy       = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b1;
    ex_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    del_pc_q.delete();
    del_instr_q.delete();
    del_cyc_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic run_until_deliveries(input int n, input int limit, input string name);
    for (int i = 0; i < limit && del_pc_q.size() < n; i++) cycle_step();
    chk(name, del_pc_q.size() >= n, 1);
  endtask

  task automatic seq_mem();
    for (int a = 0; a < 16; a++) mem[a] = {4'(a), 4'hA};
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int got, start;
    logic [IMW-1:0] e;
    rst_n = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    ex_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    w_rst_n = 1'b0; w_rsp_valid = 1'b0; w_rsp_data = '0;
    seq_mem();
    @(posedge clk); #1;

    // Wrap: RESET_PC = 14, single-cycle imem.
    chk("wrap_reset_state", w_dbg, 0);
    chk("wrap_reset_req_valid", w_req_valid, 0);
    @(posedge clk); #1;
    w_rst_n = 1'b1;
    exp_q = '{4'd14, 4'd15, 4'd0, 4'd1};
    begin
      logic w_pend;
      logic [IMW-1:0] w_addr;
      w_pend = 1'b0; w_addr = '0; got = 0;
      for (int i = 0; i < 40 && got < 4; i++) begin
        w_rsp_valid = w_pend;
        w_rsp_data  = {w_addr, 4'hA};
        @(negedge clk);
        if (w_ex_valid && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("wrap_pc", w_ex_pc, e);
          chk("wrap_instr", w_ex_instr, {e, 4'hA});
          got++;
        end
        if (w_rsp_valid) w_pend = 1'b0;
        if (w_req_valid) begin w_pend = 1'b1; w_addr = w_req_addr; end
        @(posedge clk); #1;
      end
      chk("wrap_count", got, 4);
    end
    w_rst_n = 1'b0;
    w_rsp_valid = 1'b0;

    // Reset state of the main instance.
    chk("reset_ex_valid", ex_valid, 0);
    chk("reset_ex_pc", ex_pc, 0);
    chk("reset_ex_instr", ex_instruction, 0);
    chk("reset_req_valid", imem_req_valid, 0);
    chk("reset_state", dbg_state, 0);

    // Sequential fetch, 1-cycle imem, ex_ready = 1.
    do_reset();
    lat_min = 1; lat_max = 1;
    run_until_deliveries(4, 40, "seq_timeout");
    if (del_pc_q.size() >= 4) begin
      chk("seq_pc0", del_pc_q[0], 4'd0);   chk("seq_instr0", del_instr_q[0], 8'h0A);
      chk("seq_pc1", del_pc_q[1], 4'd1);   chk("seq_instr1", del_instr_q[1], 8'h1A);
      chk("seq_pc2", del_pc_q[2], 4'd2);   chk("seq_instr2", del_instr_q[2], 8'h2A);
      chk("seq_pc3", del_pc_q[3], 4'd3);   chk("seq_instr3", del_instr_q[3], 8'h3A);
      for (int i = 1; i < 4; i++) chk("seq_gap", del_cyc_q[i] - del_cyc_q[i-1], 2);
    end

    // Back-pressure after the first instruction.
    do_reset();
    ex_ready = 1'b0;
    for (int i = 0; i < 20 && !ex_valid; i++) cycle_step();
    chk("bp_first_valid", ex_valid, 1);
    for (int i = 0; i < 5; i++) begin
      ex_ready = 1'b0;
      #1;
      chk("bp_valid", ex_valid, 1);
      chk("bp_pc", ex_pc, 4'd0);
      chk("bp_instr", ex_instruction, 8'h0A);
      chk("bp_no_req", imem_req_valid, 0);
      cycle_step();
    end
    ex_ready = 1'b1;
    run_until_deliveries(2, 20, "bp_timeout");
    if (del_pc_q.size() >= 2) chk("bp_next_pc", del_pc_q[1], 4'd1);

    // Async reset while stalled with a valid instruction held.
    ex_ready = 1'b0;
    for (int i = 0; i < 20 && !ex_valid; i++) cycle_step();
    chk("ar_pre_valid", ex_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_ex_valid", ex_valid, 0);
    chk("ar_req_valid", imem_req_valid, 0);
    chk("ar_ex_pc", ex_pc, 0);
    chk("ar_state", dbg_state, 0);
    @(posedge clk); #1;

    // Async reset during S_WAIT, then first request must be RESET_PC.
    do_reset();
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && !out_busy; i++) cycle_step();
    chk("arw_in_wait", dbg_state, 2);
    rst_n = 1'b0;
    #1;
    chk("arw_state", dbg_state, 0);
    chk("arw_req_valid", imem_req_valid, 0);
    @(posedge clk); #1;
    do_reset();
    start = acc_cnt;
    for (int i = 0; i < 10 && acc_cnt == start; i++) cycle_step();
    chk("arw_first_addr", out_addr, 4'd0);

    // Redirect one cycle after the request for pc 3 is accepted (3-cycle imem).
    do_reset();
    for (int i = 0; i < 60 && !(out_busy && out_addr == 4'd3); i++) cycle_step();
    chk("rdw_reach_pc3", out_busy && out_addr == 4'd3, 1);
    redirect_valid = 1'b1; redirect_pc = 4'd9;
    cycle_step();
    redirect_valid = 1'b0;
    start = acc_cnt;
    for (int i = 0; i < 20 && acc_cnt == start; i++) cycle_step();
    chk("rdw_next_addr", out_addr, 4'd9);
    run_until_deliveries(4, 30, "rdw_timeout");
    if (del_pc_q.size() >= 4) begin
      chk("rdw_ex_pc", del_pc_q[3], 4'd9);
      chk("rdw_ex_instr", del_instr_q[3], 8'h9A);
    end

    // Redirect coincident with the response for pc 2 (2-cycle imem).
    do_reset();
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 40 && !(out_busy && out_addr == 4'd2); i++) cycle_step();
    chk("rdc_reach_pc2", out_busy && out_addr == 4'd2, 1);
    cycle_step();
    redirect_valid = 1'b1; redirect_pc = 4'd5;
    cycle_step();
    chk("rdc_coincident", imem_rsp_valid, 1);
    redirect_valid = 1'b0;
    run_until_deliveries(4, 30, "rdc_timeout");
    if (del_pc_q.size() >= 4) begin
      chk("rdc_pc_a", del_pc_q[2], 4'd5);
      chk("rdc_pc_b", del_pc_q[3], 4'd6);
      chk("rdc_instr_b", del_instr_q[3], 8'h6A);
    end

    // Randomized run against the model.
    rst_n = 1'b0;
    for (int a = 0; a < 16; a++) mem[a] = IW'($urandom);
    do_reset();
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      ex_ready       = ($urandom_range(3, 0) != 0);
      imem_req_ready = ($urandom_range(3, 0) != 0);
      redirect_valid = ($urandom_range(15, 0) == 0);
      redirect_pc    = IMW'($urandom);
      cycle_step();
    end
    redirect_valid = 1'b0;
    chk("rand_progress", del_pc_q.size() > 100, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
